// File: rtl/instruction_fetch_if.sv
// Instruction memory bus between the fetch stage and the instruction memory.
// The fetch stage issues a request and address. The memory answers with ready
// and the instruction word in the same cycle.
interface instruction_fetch_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  // Fetch-stage side: drives the request, samples the returned word.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  // Memory side: samples the request, returns the word.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage.
// It keeps the PC, issues fetches to the instruction memory and presents each
// fetched word to the IF/ID register. It supports stall, branch redirects,
// sticky misaligned-target detection and a consumed-instruction counter.
module instruction_fetch (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [63:0]                branch_target,
  instruction_fetch_if.master        imem,
  output logic [31:0]                Instruction,
  output logic [63:0]                PC_Out,
  output logic                       fetch_valid,
  output logic                       misalign_err,
  output logic [31:0]                fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] count_q, count_d;

  logic        req_s;
  logic        handshake_s;

  // Request generation.
  // A stalled, valid output has no room for a new word, so the fetch is held off.
  always_comb begin
    req_s = 1'b0;
    if (state_q == S_RUN) begin
      req_s = !(stall && valid_q);
    end else begin
      req_s = 1'b0;
    end
    handshake_s = req_s && imem.imem_ready && !branch_taken;
  end

  // Next-state and datapath update. The order of precedence is branch, then stall, then handshake.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    err_d    = err_q;
    count_d  = count_q;

    // Count only words that leave the stage: valid, not stalled, not flushed.
    if (valid_q && !stall && !branch_taken) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end

    if (branch_taken) begin
      pc_d     = {branch_target[63:2], 2'b00};
      instr_d  = 32'd0;
      pc_out_d = 64'd0;
      valid_d  = 1'b0;
      state_d  = S_REDIRECT;
      if (branch_target[1:0] != 2'b00) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
        end
        S_REDIRECT: begin
          state_d = S_RUN;
        end
        S_RUN: begin
          if (handshake_s) begin
            instr_d  = imem.imem_rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 64'd4;
          end else if (!stall) begin
            instr_d  = 32'd0;
            pc_out_d = 64'd0;
            valid_d  = 1'b0;
          end else begin
            instr_d  = instr_q;
            pc_out_d = pc_out_q;
            valid_d  = valid_q;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= 64'd0;
      instr_q  <= 32'd0;
      pc_out_q <= 64'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  assign imem.imem_req  = req_s;
  assign imem.imem_addr = pc_q;
  assign Instruction    = instr_q;
  assign PC_Out         = pc_out_q;
  assign fetch_valid    = valid_q;
  assign misalign_err   = err_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch.
// It runs directed scenarios followed by randomized traffic. A behavioural
// reference model tracks the PC, the output word, the counter and the number of
// dead cycles before fetching resumes.
module tb_instruction_fetch;
  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [31:0] Instruction;
  logic [63:0] PC_Out;
  logic        fetch_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  instruction_fetch_if imem_bus ();

  instruction_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem_bus),
    .Instruction   (Instruction),
    .PC_Out        (PC_Out),
    .fetch_valid   (fetch_valid),
    .misalign_err  (misalign_err),
    .fetch_count   (fetch_count)
  );

  int n_checks   = 0;
  int n_failures = 0;

  // Memory contents: a fixed, address-dependent word.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[33:2] ^ 32'h1357_9BDF ^ a[63:32];
  endfunction

  assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [63:0] m_pcout;
  logic        m_valid;
  logic        m_err;
  logic [31:0] m_count;
  int          m_dead;

  task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_failures++;
      $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'd0; m_instr = 32'd0; m_pcout = 64'd0; m_valid = 1'b0;
    m_err = 1'b0; m_count = 32'd0; m_dead = 1;
  endtask

  function automatic logic model_req(input logic s);
    return (m_dead == 0) && !(s && m_valid);
  endfunction

  task automatic compare_all(input logic s);
    check_eq("imem_req",     {63'd0, imem_bus.imem_req}, {63'd0, model_req(s)});
    check_eq("imem_addr",    imem_bus.imem_addr, m_pc);
    check_eq("Instruction",  {32'd0, Instruction}, {32'd0, m_instr});
    check_eq("PC_Out",       PC_Out, m_pcout);
    check_eq("fetch_valid",  {63'd0, fetch_valid}, {63'd0, m_valid});
    check_eq("misalign_err", {63'd0, misalign_err}, {63'd0, m_err});
    check_eq("fetch_count",  {32'd0, fetch_count}, {32'd0, m_count});
  endtask

  task automatic model_step(input logic s, input logic bt, input logic [63:0] tgt, input logic rdy);
    logic req;
    req = model_req(s);
    if (m_valid && !s && !bt) m_count = m_count + 32'd1;
    if (bt) begin
      m_pc = tgt & ~64'd3;
      m_instr = 32'd0; m_pcout = 64'd0; m_valid = 1'b0;
      m_dead = 1;
      if (tgt[1:0] != 2'b00) m_err = 1'b1;
    end else if (m_dead > 0) begin
      m_dead = m_dead - 1;
    end else if (req && rdy) begin
      m_instr = mem_word(m_pc); m_pcout = m_pc; m_valid = 1'b1;
      m_pc = m_pc + 64'd4;
    end else if (!s) begin
      m_instr = 32'd0; m_pcout = 64'd0; m_valid = 1'b0;
    end
  endtask

  // One cycle: drive inputs just after negedge, check, advance model over the posedge.
  task automatic cycle(input logic s, input logic bt, input logic [63:0] tgt, input logic rdy);
    stall = s; branch_taken = bt; branch_target = tgt; imem_bus.imem_ready = rdy;
    #1;
    compare_all(s);
    model_step(s, bt, tgt, rdy);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'd0;
    imem_bus.imem_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("reset_req", {63'd0, imem_bus.imem_req}, 64'd0);
    check_eq("reset_count", {32'd0, fetch_count}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Streaming from reset: one idle cycle, then PC_Out 0, 4 and 8.
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    #1 check_eq("stream_pc0", PC_Out, 64'h0);
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    #1 check_eq("stream_pc4", PC_Out, 64'h4);
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    #1 check_eq("stream_pc8", PC_Out, 64'h8);
    // Run on to PC 0x10, then let memory wait for 3 cycles.
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 64'd0, 1'b0);
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    #1 check_eq("wait_pc10", PC_Out, 64'h10);
    // Stall for 2 cycles while the output is valid.
    cycle(1'b1, 1'b0, 64'd0, 1'b1);
    cycle(1'b1, 1'b0, 64'd0, 1'b1);
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    // Branch while stalled.
    cycle(1'b1, 1'b1, 64'h200, 1'b1);
    cycle(1'b1, 1'b0, 64'd0, 1'b1);
    #1 check_eq("redir_addr", imem_bus.imem_addr, 64'h200);
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    // Wrap of the PC at the top of the address space.
    cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
    // Misaligned target: the error is sticky.
    cycle(1'b0, 1'b1, 64'h103, 1'b1);
    #1 check_eq("misalign_pc", imem_bus.imem_addr, 64'h100);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
    #1 check_eq("misalign_sticky", {63'd0, misalign_err}, 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [63:0] tgt;
      tgt = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), tgt,
            ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset between edges while memory is waiting.
    stall = 1'b0; branch_taken = 1'b0; imem_bus.imem_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("async_req",   {63'd0, imem_bus.imem_req}, 64'd0);
    check_eq("async_addr",  imem_bus.imem_addr, 64'd0);
    check_eq("async_instr", {32'd0, Instruction}, 64'd0);
    check_eq("async_pcout", PC_Out, 64'd0);
    check_eq("async_valid", {63'd0, fetch_valid}, 64'd0);
    check_eq("async_err",   {63'd0, misalign_err}, 64'd0);
    check_eq("async_count", {32'd0, fetch_count}, 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0),
            {$urandom, $urandom} & ~64'd3, ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 SHALL have port stall, input, 1, downstream IF/ID register holding this cycle, so the current output is not consumed.
REQ-004 SHALL have port branch_taken, input, 1, redirect request from the resolve stage.
REQ-005 SHALL have port branch_target, input, 64, redirect PC.
REQ-006 SHALL have port imem_rdata, input, 32, instruction word, valid when imem_ready=1.
REQ-007 SHALL have port imem_ready, input, 1, memory accepts the request and returns imem_rdata in the same cycle.
REQ-008 SHALL have port imem_req, output, 1, fetch request.
REQ-009 SHALL have port imem_addr, output, 64, fetch address; equals the internal PC register.
REQ-010 SHALL have port Instruction, output, 32, fetched word presented to IF/ID.
REQ-011 SHALL have port PC_Out, output, 64, address of Instruction.
REQ-012 SHALL have port fetch_valid, output, 1, Instruction/PC_Out hold a real instruction.
REQ-013 SHALL have port misalign_err, output, 1, sticky flag: a redirect target had nonzero bits [1:0].
REQ-014 SHALL have port fetch_count, output, 32, count of instructions consumed downstream.

Function
REQ-015 SHALL implement the FSM states S_IDLE, S_RUN and S_REDIRECT.
REQ-016 S_IDLE SHALL be entered on reset, drive imem_req=0 and move to S_RUN on the first clk edge after reset deasserts.
REQ-017 S_REDIRECT SHALL last exactly one cycle with imem_req=0, then move to S_RUN.
REQ-018 In S_RUN, imem_req SHALL be 1 except when stall=1 and fetch_valid=1, which gives 0.
REQ-019 A handshake SHALL be imem_req=1 and imem_ready=1 and branch_taken=0.
REQ-020 On a handshake edge: Instruction<=imem_rdata, PC_Out<=PC, fetch_valid<=1, PC<=PC+4 (64-bit modulo, wraps 0xFFFF_FFFF_FFFF_FFFC -> 0).
REQ-021 S_RUN with no handshake and stall=0 SHALL insert a bubble: Instruction<=0, PC_Out<=0, fetch_valid<=0.
REQ-022 S_RUN with no handshake and stall=1 SHALL hold Instruction, PC_Out and fetch_valid unchanged.
REQ-023 imem_addr SHALL remain stable while imem_req=1 and imem_ready=0.
REQ-024 branch_taken=1 in any state SHALL, at the edge: set PC<=branch_target with bits [1:0] forced to 0; Instruction<=0; PC_Out<=0; fetch_valid<=0; go to S_REDIRECT; drop any same-cycle imem_rdata.
REQ-025 branch_taken SHALL override stall, so the flush occurs even while stalled.
REQ-026 If branch_taken=1 and branch_target[1:0]!=0, misalign_err<=1, held until reset.
REQ-027 fetch_count SHALL increment by 1 on each edge with fetch_valid=1, stall=0 and branch_taken=0, and wrap at 2^32.
REQ-028 Priority SHALL be reset > branch_taken > stall > handshake.
REQ-029 Fetch-to-output latency SHALL be 1 cycle after the handshake edge.
REQ-030 Branch penalty SHALL be 2 cycles: the redirect edge, then S_REDIRECT, before the first request at the target.

Reset
REQ-031 On reset assertion, outputs SHALL immediately be: PC=0, imem_addr=0, imem_req=0, Instruction=0, PC_Out=0, fetch_valid=0, misalign_err=0, fetch_count=0, state=S_IDLE.
REQ-032 Reset asserted mid-wait or mid-redirect SHALL abandon the request; after release, fetching restarts at PC 0.

Verification
REQ-033 Reset release, imem_ready=1, stall=0 -> S_IDLE for 1 cycle; PC_Out then reads 0, 4, 8 on consecutive cycles with fetch_valid=1; fetch_count increments each cycle.
REQ-034 imem_ready=0 for 3 cycles at PC 0x10 -> imem_addr stays 0x10, 3 bubbles (Instruction=0), then PC_Out=0x10.
REQ-035 stall=1 for 2 cycles with fetch_valid=1 -> imem_req=0, Instruction/PC_Out held, fetch_count frozen; fetching resumes at the next PC once stall drops.
REQ-036 branch_taken=1, target 0x200, while stall=1 and imem_ready=1 -> next cycle fetch_valid=0, state S_REDIRECT, then imem_addr=0x200 with imem_req=1.
REQ-037 branch_target 0x103 -> PC=0x100, misalign_err=1, still 1 after 10 further cycles.
REQ-038 reset pulsed asynchronously between clk edges during a wait -> all outputs 0 immediately; first fetch after release at 0x0.
